// File: rtl/bcd_counter_display.sv
// Purpose: tick divider driving a DIGITS-wide BCD up/down counter, time-multiplexed onto one 7-segment bus.
// Latency: tick 1 cycle after divider terminal count; count/wrap update on the tick-cycle edge; display 1 cycle behind count/scan.
// Backpressure: none; free-running, every input sampled on every clk_50MHz edge.
module bcd_counter_display #(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1,
  parameter int SCAN_HZ    = 1000,
  parameter int DIGITS     = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int LZ_BLANK   = 0
) (
  input  logic                clk_50MHz,
  input  logic                reset,
  input  logic                enable,
  input  logic                up_down,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic                tick,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic                wrap,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   digit_sel
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int SDIV = CLK_HZ / SCAN_HZ;
  localparam int DW   = $clog2(DIV);
  localparam int SW   = $clog2(SDIV);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] SDIV_LAST = SW'(SDIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [DW-1:0]       div_cnt;
  logic [SW-1:0]       sdiv_cnt;
  logic [IW-1:0]       scan_idx;
  logic [4*DIGITS-1:0] cnt_nxt;
  logic                wrap_nxt;
  logic                carry;
  logic [3:0]          dg;
  logic [3:0]          dg_nxt;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_above;
  logic [3:0]          scan_digit;
  logic                scan_blank;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   sel_raw;

  // gfedcba pattern, active-high; non-decimal codes are blank
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'h3F;
      4'd1:    seg_enc = 7'h06;
      4'd2:    seg_enc = 7'h5B;
      4'd3:    seg_enc = 7'h4F;
      4'd4:    seg_enc = 7'h66;
      4'd5:    seg_enc = 7'h6D;
      4'd6:    seg_enc = 7'h7D;
      4'd7:    seg_enc = 7'h07;
      4'd8:    seg_enc = 7'h7F;
      4'd9:    seg_enc = 7'h6F;
      default: seg_enc = 7'h00;
    endcase
  endfunction

  // Free-running tick divider; tick is the registered terminal-count flag
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      tick    <= (div_cnt == DIV_LAST);
    end
  end

  // Next count: load (with out-of-range digits forced to 0) beats a ripple BCD step
  always_comb begin
    cnt_nxt  = count_bcd;
    wrap_nxt = 1'b0;
    carry    = 1'b0;
    dg       = 4'd0;
    dg_nxt   = 4'd0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        dg = load_value[4*i +: 4];
        cnt_nxt[4*i +: 4] = (dg > 4'd9) ? 4'd0 : dg;
      end
    end else if (tick && enable) begin
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        dg     = count_bcd[4*i +: 4];
        dg_nxt = dg;
        if (carry) begin
          if (up_down) begin
            if (dg == 4'd9) dg_nxt = 4'd0;
            else begin dg_nxt = dg + 4'd1; carry = 1'b0; end
          end else begin
            if (dg == 4'd0) dg_nxt = 4'd9;
            else begin dg_nxt = dg - 4'd1; carry = 1'b0; end
          end
        end
        cnt_nxt[4*i +: 4] = dg_nxt;
      end
      // carry surviving past the top digit means every digit rolled over
      wrap_nxt = carry;
    end
  end

  // Count and wrap registers
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      count_bcd <= '0;
      wrap      <= 1'b0;
    end else begin
      count_bcd <= cnt_nxt;
      wrap      <= wrap_nxt;
    end
  end

  // Scan divider and digit index
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      sdiv_cnt <= '0;
      scan_idx <= '0;
    end else begin
      sdiv_cnt <= (sdiv_cnt == SDIV_LAST) ? '0 : sdiv_cnt + SW'(1);
      if (sdiv_cnt == SDIV_LAST)
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end
  end

  // Leading-zero mask (top-down) and selection of the scanned digit
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    scan_digit = 4'd0;
    scan_blank = 1'b0;
    sel_raw    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (count_bcd[4*i +: 4] == 4'd0);
      lz_mask[i] = (LZ_BLANK != 0) && (i != 0) && zero_above;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IW'(i)) begin
        scan_digit = count_bcd[4*i +: 4];
        scan_blank = lz_mask[i];
        sel_raw[i] = 1'b1;
      end
    end
    seg_raw = scan_blank ? 7'h00 : seg_enc(scan_digit);
  end

  // Display output register; polarity applied here so outputs are glitch-free
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      seg       <= (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
      digit_sel <= (ACTIVE_LOW != 0) ? ~DIGITS'(1) : DIGITS'(1);
    end else begin
      seg       <= (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
      digit_sel <= (ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
    end
  end

endmodule
